// File: rtl/data_mem_arbiter_pkg.sv
// Shared encodings for the data memory arbiter: FSM states, access sizes
// and owner codes.
package data_mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DBG  = 1'b1
    } owner_t;

endpackage

// File: rtl/data_mem_align_chk.sv
// Flags accesses that must not reach memory: misaligned halfword/word or
// the reserved size code.
module data_mem_align_chk
    import data_mem_arbiter_pkg::*;
(
    input  logic [1:0] addr,
    input  logic [1:0] size,
    output logic       err
);

    always_comb begin
        err = 1'b0;
        case (size)
            SZ_B:    err = 1'b0;
            SZ_H:    err = addr[0];
            SZ_W:    err = |addr;
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-master arbiter (core MemoryAccess stage, debug/loader) in front of the
// single-port data memory; every access walks IDLE -> ISSUE -> [WAIT] -> RESP.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int AWIDTH   = 14,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic [AWIDTH-1:0] c_addr,
    input  logic [XLEN-1:0]   c_wdata,
    input  logic [2:0]        c_we,
    output logic              c_ack,
    output logic              c_err,
    output logic [XLEN-1:0]   c_rdata,
    output logic              stall_memoryaccess,
    input  logic              d_req,
    input  logic [AWIDTH-1:0] d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    input  logic [2:0]        d_we,
    output logic              d_ack,
    output logic              d_err,
    output logic [XLEN-1:0]   d_rdata,
    output logic [AWIDTH-1:0] data_mem_addr,
    output logic [XLEN-1:0]   data_mem_wdata,
    output logic [2:0]        data_mem_we,
    input  logic [XLEN-1:0]   data_mem_out,
    output logic              busy
);

    localparam logic [2:0] LAT_CNT = 3'(READ_LAT);

    state_t      state_reg;
    owner_t      owner_reg;
    owner_t      last_grant_reg;
    logic        write_reg;
    logic [2:0]  cnt_reg;

    owner_t            sel_owner;
    logic [AWIDTH-1:0] sel_addr;
    logic [XLEN-1:0]   sel_wdata;
    logic [2:0]        sel_we;
    logic              sel_err;

    // Round-robin: on a tie the requester that was not served last wins.
    always_comb begin
        sel_owner = OWN_CORE;
        if (c_req && d_req) begin
            sel_owner = (last_grant_reg == OWN_DBG) ? OWN_CORE : OWN_DBG;
        end else if (d_req) begin
            sel_owner = OWN_DBG;
        end
        sel_addr  = (sel_owner == OWN_DBG) ? d_addr  : c_addr;
        sel_wdata = (sel_owner == OWN_DBG) ? d_wdata : c_wdata;
        sel_we    = (sel_owner == OWN_DBG) ? d_we    : c_we;
    end

    data_mem_align_chk u_align_chk (
        .addr (sel_addr[1:0]),
        .size (sel_we[1:0]),
        .err  (sel_err)
    );

    assign stall_memoryaccess = c_req & ~c_ack;
    assign busy               = (state_reg != ST_IDLE);

    // Outputs are registered on the transition into the state they belong to,
    // so ack/err/rdata are visible during RESP/ERR and data_mem_we during ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            owner_reg      <= OWN_CORE;
            last_grant_reg <= OWN_DBG;
            write_reg      <= 1'b0;
            cnt_reg        <= 3'd0;
            data_mem_addr  <= '0;
            data_mem_wdata <= '0;
            data_mem_we    <= 3'b000;
            c_ack          <= 1'b0;
            c_err          <= 1'b0;
            c_rdata        <= '0;
            d_ack          <= 1'b0;
            d_err          <= 1'b0;
            d_rdata        <= '0;
        end else begin
            c_ack       <= 1'b0;
            d_ack       <= 1'b0;
            data_mem_we <= 3'b000;
            case (state_reg)
                ST_IDLE: begin
                    if (c_req || d_req) begin
                        owner_reg      <= sel_owner;
                        last_grant_reg <= sel_owner;
                        write_reg      <= sel_we[2];
                        if (sel_err) begin
                            state_reg <= ST_ERR;
                            if (sel_owner == OWN_DBG) begin
                                d_ack   <= 1'b1;
                                d_err   <= 1'b1;
                                d_rdata <= '0;
                            end else begin
                                c_ack   <= 1'b1;
                                c_err   <= 1'b1;
                                c_rdata <= '0;
                            end
                        end else begin
                            state_reg      <= ST_ISSUE;
                            data_mem_addr  <= sel_addr;
                            data_mem_wdata <= sel_wdata;
                            data_mem_we    <= sel_we;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (write_reg) begin
                        state_reg <= ST_RESP;
                        if (owner_reg == OWN_DBG) begin
                            d_ack <= 1'b1;
                            d_err <= 1'b0;
                        end else begin
                            c_ack <= 1'b1;
                            c_err <= 1'b0;
                        end
                    end else begin
                        cnt_reg   <= LAT_CNT;
                        state_reg <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg == 3'd1) begin
                        state_reg <= ST_RESP;
                        if (owner_reg == OWN_DBG) begin
                            d_ack   <= 1'b1;
                            d_err   <= 1'b0;
                            d_rdata <= data_mem_out;
                        end else begin
                            c_ack   <= 1'b1;
                            c_err   <= 1'b0;
                            c_rdata <= data_mem_out;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 3'd1;
                    end
                end
                ST_RESP: state_reg <= ST_IDLE;
                ST_ERR:  state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
